// File: rtl/soc_tcdm2apb_bridge.sv
// TCDM req/gnt/r_valid to APB4 master bridge, one transfer in flight at a time.
// Optional ACCESS-phase timeout abort enabled by defining APB_BRIDGE_TIMEOUT_EN.
`timescale 1ns/1ps
module soc_tcdm2apb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic [ADDR_WIDTH-1:0]   add_i,
  input  logic                    wen_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  output logic                    gnt_o,
  output logic                    r_valid_o,
  output logic [DATA_WIDTH-1:0]   r_rdata_o,
  output logic                    r_opc_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic                    psel_o,
  output logic                    penable_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0] state_r;
  logic       unused_s;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_r;
`else
  localparam logic [15:0] unused_timeout = 16'(TIMEOUT_CYCLES);
`endif

  // Word-aligned APB address: the byte offset bits are dropped deliberately.
  assign unused_s = ^add_i[1:0];

  // Grant only while idle; held low while reset is asserted.
  assign gnt_o = (state_r == IDLE) & req_i & rst_ni;

  // Transfer sequencing and all registered bus/response outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      r_valid_o <= 1'b0;
      r_rdata_o <= '0;
      r_opc_o   <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pwrite_o  <= 1'b0;
      pstrb_o   <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      tmo_cnt_r <= 16'd0;
`endif
    end else begin
      r_valid_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_i) begin
            paddr_o  <= {add_i[ADDR_WIDTH-1:2], 2'b00};
            pwdata_o <= wdata_i;
            pwrite_o <= ~wen_i;
            pstrb_o  <= wen_i ? '0 : be_i;
            psel_o   <= 1'b1;
            state_r  <= SETUP;
          end else begin
            state_r  <= IDLE;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state_r   <= ACCESS;
`ifdef APB_BRIDGE_TIMEOUT_EN
          tmo_cnt_r <= 16'd0;
`endif
        end
        ACCESS: begin
          // A ready slave wins over a timeout landing in the same cycle.
          if (pready_i) begin
            r_rdata_o <= pwrite_o ? '0 : prdata_i;
            r_opc_o   <= pslverr_i;
            r_valid_o <= 1'b1;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            state_r   <= RESP;
          end
`ifdef APB_BRIDGE_TIMEOUT_EN
          else if (tmo_cnt_r == TIMEOUT_LAST) begin
            r_rdata_o <= 32'hBADA_CCE5;
            r_opc_o   <= 1'b1;
            r_valid_o <= 1'b1;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            state_r   <= RESP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
          end
`else
          else begin
            state_r <= ACCESS;
          end
`endif
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soc_tcdm2apb_bridge.sv
// Scoreboard bench for soc_tcdm2apb_bridge; timeout case runs when APB_BRIDGE_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_soc_tcdm2apb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] add_i = 32'h0;
  logic        wen_i = 1'b1;
  logic [31:0] wdata_i = 32'h0;
  logic [3:0]  be_i = 4'h0;
  logic        gnt_o, r_valid_o, r_opc_o, pwrite_o, psel_o, penable_o;
  logic [31:0] r_rdata_o, paddr_o, pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i = 1'b0;
  logic [31:0] prdata_i = 32'h0;
  logic        pslverr_i = 1'b0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        opc;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  soc_tcdm2apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .pwrite_o(pwrite_o), .pstrb_o(pstrb_o), .psel_o(psel_o), .penable_o(penable_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic opc);
    resp_t e;
    e.rdata = rdata;
    e.opc   = opc;
    exp_q.push_back(e);
  endtask

  // Response monitor: every r_valid_o pulse must match the oldest expectation.
  always @(negedge clk_i) begin
    resp_t e;
    if (r_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("r_rdata", r_rdata_o, e.rdata);
        check_eq("r_opc", {31'd0, r_opc_o}, {31'd0, e.opc});
      end
    end
  end

  // Starts at a negedge in IDLE, ends at a negedge back in IDLE.
  task automatic run_txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                         input logic [3:0] be, input int waits, input logic [31:0] rdata,
                         input logic err);
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    exp_addr = {addr[31:2], 2'b00};
    exp_strb = wen ? 4'h0 : be;
    req_i = 1'b1; add_i = addr; wen_i = wen; wdata_i = wdata; be_i = be; pready_i = 1'b0;
    #1;
    check_eq("gnt_idle", {31'd0, gnt_o}, 32'd1);
    push_exp(wen ? rdata : 32'h0, err);
    @(negedge clk_i);
    req_i = 1'b0; add_i = $urandom; wdata_i = $urandom; wen_i = ~wen;
    check_eq("setup_psel", {31'd0, psel_o}, 32'd1);
    check_eq("setup_penable", {31'd0, penable_o}, 32'd0);
    check_eq("paddr", paddr_o, exp_addr);
    check_eq("pwrite", {31'd0, pwrite_o}, {31'd0, ~wen});
    check_eq("pstrb", {28'd0, pstrb_o}, {28'd0, exp_strb});
    check_eq("pwdata", pwdata_o, wdata);
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk_i);
      check_eq("access_psel", {31'd0, psel_o}, 32'd1);
      check_eq("access_penable", {31'd0, penable_o}, 32'd1);
      check_eq("access_paddr", paddr_o, exp_addr);
      check_eq("access_pstrb", {28'd0, pstrb_o}, {28'd0, exp_strb});
      check_eq("access_pwdata", pwdata_o, wdata);
      if (w == waits) begin
        pready_i = 1'b1; prdata_i = rdata; pslverr_i = err;
      end else begin
        pready_i = 1'b0; prdata_i = $urandom; pslverr_i = ~err;
      end
    end
    @(negedge clk_i);
    pready_i = 1'b0; pslverr_i = 1'b0;
    check_eq("resp_valid", {31'd0, r_valid_o}, 32'd1);
    check_eq("resp_psel", {31'd0, psel_o}, 32'd0);
    check_eq("resp_penable", {31'd0, penable_o}, 32'd0);
    @(negedge clk_i);
    check_eq("valid_pulse", {31'd0, r_valid_o}, 32'd0);
  endtask

  initial begin
    int g0, g1, ng, n_acc;
    @(negedge clk_i);
    check_eq("rst_gnt", {31'd0, gnt_o}, 32'd0);
    check_eq("rst_rvalid", {31'd0, r_valid_o}, 32'd0);
    check_eq("rst_rdata", r_rdata_o, 32'd0);
    check_eq("rst_opc", {31'd0, r_opc_o}, 32'd0);
    check_eq("rst_paddr", paddr_o, 32'd0);
    check_eq("rst_pwdata", pwdata_o, 32'd0);
    check_eq("rst_pctl", {28'd0, pwrite_o, psel_o, penable_o, 1'b0}, 32'd0);
    check_eq("rst_pstrb", {28'd0, pstrb_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_txn(32'h1A10_4004, 1'b1, 32'h0000_0000, 4'hF, 0, 32'h1234_5678, 1'b0);
    run_txn(32'h1A10_4010, 1'b0, 32'hCAFE_F00D, 4'b0011, 3, 32'hDEAD_BEEF, 1'b0);
    run_txn(32'h1A10_4020, 1'b1, 32'h1111_1111, 4'hF, 2, 32'h55AA_55AA, 1'b1);
    run_txn(32'h1A10_4024, 1'b1, 32'h2222_2222, 4'hF, 1, 32'h0BAD_F00D, 1'b0);
    run_txn(32'h1A10_4007, 1'b1, 32'h3333_3333, 4'hF, 0, 32'h7777_0001, 1'b0);
    run_txn(32'h1A10_4032, 1'b0, 32'h8765_4321, 4'b1100, 1, 32'hFFFF_FFFF, 1'b1);

    // Back-to-back: request held for two reads.
    g0 = -1; g1 = -1; ng = 0;
    push_exp(32'hA5A5_0001, 1'b0);
    push_exp(32'hA5A5_0001, 1'b0);
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h1A10_4040;
    pready_i = 1'b1; prdata_i = 32'hA5A5_0001; pslverr_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) req_i = 1'b0;
      #1;
      if (gnt_o === 1'b1) begin
        ng++;
        if (g0 < 0) g0 = i;
        else if (g1 < 0) g1 = i;
      end
      @(negedge clk_i);
    end
    pready_i = 1'b0;
    check_eq("b2b_gnt_count", ng, 32'd2);
    check_eq("b2b_first_gnt", g0, 32'd0);
    check_eq("b2b_second_gnt", g1, 32'd4);

    // Reset during ACCESS: outputs clear at once and no response follows.
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h1A10_4050; pready_i = 1'b0;
    @(negedge clk_i);
    req_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("pre_rst_penable", {31'd0, penable_o}, 32'd1);
    rst_ni = 1'b0;
    req_i = 1'b1;
    #1;
    check_eq("arst_gnt", {31'd0, gnt_o}, 32'd0);
    check_eq("arst_psel", {31'd0, psel_o}, 32'd0);
    check_eq("arst_penable", {31'd0, penable_o}, 32'd0);
    check_eq("arst_paddr", paddr_o, 32'd0);
    check_eq("arst_rdata", r_rdata_o, 32'd0);
    check_eq("arst_pctl", {28'd0, pwrite_o, r_opc_o, r_valid_o, 1'b0}, 32'd0);
    req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    pready_i = 1'b1;
    repeat (6) @(negedge clk_i);
    pready_i = 1'b0;

    run_txn(32'h1A10_4060, 1'b1, 32'h0, 4'hF, 1, 32'h600D_0001, 1'b0);

`ifdef APB_BRIDGE_TIMEOUT_EN
    // Slave never ready: abort after 8 ACCESS cycles.
    push_exp(32'hBADA_CCE5, 1'b1);
    req_i = 1'b1; wen_i = 1'b1; add_i = 32'h1A10_4070; pready_i = 1'b0;
    @(negedge clk_i);
    req_i = 1'b0;
    @(negedge clk_i);
    n_acc = 0;
    while (penable_o === 1'b1 && n_acc < 40) begin
      n_acc++;
      @(negedge clk_i);
    end
    check_eq("timeout_cycles", n_acc, 32'd8);
    check_eq("timeout_psel", {31'd0, psel_o}, 32'd0);
    @(negedge clk_i);
`else
    n_acc = 0;
`endif

    repeat (2) @(negedge clk_i);
    check_eq("resp_pending", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
